// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth sequential multiplier.
package booth_pkg;

   localparam int B_WIDTH = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Booth recode pairs {Q[0], Q_1}
   localparam logic [1:0] REC_NOP     = 2'b00;
   localparam logic [1:0] REC_NOP_ALT = 2'b11;
   localparam logic [1:0] REC_ADD     = 2'b01;
   localparam logic [1:0] REC_SUB     = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// Combinational (WIDTH+1)-bit A +/- M around a carry-lookahead adder;
// the operation is picked by the Booth recode pair.
module booth_addsub
   import booth_pkg::*;
#(
   parameter int WIDTH = B_WIDTH
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] m,
   input  logic [1:0]     rec,
   output logic [WIDTH:0] s
);

   localparam int N = WIDTH + 1;

   logic [N-1:0] b;
   logic         cin;
   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N-1:0] c;

   // Subtract is A + ~M + 1; the no-op pairs present a zero operand.
   always_comb begin
      b   = '0;
      cin = 1'b0;
      case (rec)
         REC_ADD: b = m;
         REC_SUB: begin
            b   = ~m;
            cin = 1'b1;
         end
         default: b = '0;
      endcase
   end

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is a flat sum of generate/propagate products, not a ripple.
   always_comb begin
      logic t;
      logic pp;
      c    = '0;
      c[0] = cin;
      t    = 1'b0;
      pp   = 1'b0;
      for (int i = 0; i < N - 1; i++) begin
         t  = g[i];
         pp = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            t  = t | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = t | (pp & cin);
      end
   end

   assign s = p ^ c;

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier controller, one recode step per cycle.
// Optional: BOOTH_ZERO_BYPASS_EN skips the RUN phase when an operand is zero.
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = B_WIDTH,
   parameter int CNT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   state_t               state_q, state_d;
   logic [WIDTH:0]       a_q, a_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic                 q1_q, q1_d;
   logic [WIDTH:0]       m_q, m_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 done_q, done_d;

   logic [WIDTH:0]       s;
   logic [1:0]           rec;
   logic                 zero_op;

`ifdef BOOTH_ZERO_BYPASS_EN
   assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
   assign zero_op = 1'b0;
`endif

   assign rec = {q_q[0], q1_q};

   booth_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a   (a_q),
      .m   (m_q),
      .rec (rec),
      .s   (s)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      q_d       = q_q;
      q1_d      = q1_q;
      m_d       = m_q;
      count_d   = count_q;
      product_d = product_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && zero_op) begin
               product_d = '0;
               done_d    = 1'b1;
            end else if (start) begin
               a_d     = '0;
               q_d     = multiplier;
               q1_d    = 1'b0;
               m_d     = {multiplicand[WIDTH-1], multiplicand};
               count_d = CNT_W'(WIDTH);
               state_d = RUN;
            end
         end
         RUN: begin
            // Arithmetic right shift of {S, Q, Q_1}
            a_d     = {s[WIDTH], s[WIDTH:1]};
            q_d     = {s[0], q_q[WIDTH-1:1]};
            q1_d    = q_q[0];
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               product_d = {a_d[WIDTH-1:0], q_d};
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         m_q       <= '0;
         count_q   <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         m_q       <= m_d;
         count_q   <= count_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = done_q;
   assign product = product_q;

endmodule
